// File: rtl/ir_nec_pkg.sv
// Shared NEC infrared definitions: FSM states, frame timing in 50 MHz clock
// cycles, and the field layout of the 32-bit frame word.
package ir_nec_pkg;

  localparam int NEC_LEAD_MARK  = 450000;
  localparam int NEC_LEAD_SPACE = 225000;
  localparam int NEC_REP_SPACE  = 112500;
  localparam int NEC_BIT_MARK   = 28125;
  localparam int NEC_ZERO_SPACE = 28125;
  localparam int NEC_ONE_SPACE  = 84375;
  localparam int NEC_GAP_LEN    = 2000000;
  localparam int NEC_CARR_HALF  = 658;

  // Phase counter width; must hold the longest phase (the 40 ms gap).
  localparam int PH_W = 21;

  // Frame word layout, transmitted LSB first.
  localparam int FLD_W          = 8;
  localparam int FLD_ADDR_LSB   = 0;
  localparam int FLD_ADDR_N_LSB = 8;
  localparam int FLD_CMD_LSB    = 16;
  localparam int FLD_CMD_N_LSB  = 24;
  localparam int LAST_BIT       = 31;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD_M = 3'd1,
    ST_LEAD_S = 3'd2,
    ST_BIT_M  = 3'd3,
    ST_BIT_S  = 3'd4,
    ST_STOP_M = 3'd5,
    ST_GAP    = 3'd6
  } nec_state_e;

  // Mark states are the ones that pull the line low and light the LED.
  function automatic logic is_mark(nec_state_e s);
    return (s == ST_LEAD_M) || (s == ST_BIT_M) || (s == ST_STOP_M);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// 38 kHz carrier for the IR LED. The carrier restarts high at every mark
// entry so each burst begins with a full high half-period; the output is
// registered and already gated with the mark enable.
module ir_carrier_gen
  import ir_nec_pkg::*;
#(
  parameter int CARR_HALF = NEC_CARR_HALF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_restart,
  output logic o_carrier
);

  localparam int            CW = (CARR_HALF > 1) ? $clog2(CARR_HALF) : 1;
  localparam logic [CW-1:0] TC = CW'(CARR_HALF - 1);

  logic [CW-1:0] r_cnt;
  logic          r_phase;
  logic          r_led;

  // Half-period counter and phase; LED forced low whenever not enabled.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_led   <= 1'b0;
    end else if (i_restart) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
      r_led   <= 1'b1;
    end else if (i_en) begin
      if (r_cnt == TC) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
        r_led   <= ~r_phase;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
        r_led   <= r_phase;
      end
    end else begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_led   <= 1'b0;
    end
  end

  assign o_carrier = r_led;

endmodule

// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: serialises a 32-bit frame or a repeat code into
// mark/space timing on a demodulated line plus a carrier-modulated LED drive.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | ready, line high, waiting for iSEND / iREPEAT
// LEAD_M  | 9 ms leader mark
// LEAD_S  | leader space: 4.5 ms (frame) or 2.25 ms (repeat, r_rep=1)
// BIT_M   | 562.5 us bit mark
// BIT_S   | bit space, length set by current LSB of the shift register
// STOP_M  | 562.5 us trailing mark
// GAP     | enforced 40 ms idle space, oDONE on its last cycle
module ir_nec_tx
  import ir_nec_pkg::*;
#(
  parameter int LEAD_MARK  = NEC_LEAD_MARK,
  parameter int LEAD_SPACE = NEC_LEAD_SPACE,
  parameter int REP_SPACE  = NEC_REP_SPACE,
  parameter int BIT_MARK   = NEC_BIT_MARK,
  parameter int ZERO_SPACE = NEC_ZERO_SPACE,
  parameter int ONE_SPACE  = NEC_ONE_SPACE,
  parameter int GAP_LEN    = NEC_GAP_LEN,
  parameter int CARR_HALF  = NEC_CARR_HALF
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iSEND,
  input  logic        iREPEAT,
  input  logic [31:0] iDATA,
  output logic        oREADY,
  output logic        oDONE,
  output logic        oIRDA,
  output logic        oIR_LED
);

  // Terminal counts: a phase ends when the counter reaches length-1.
  localparam logic [PH_W-1:0] LEAD_MARK_TC  = PH_W'(LEAD_MARK - 1);
  localparam logic [PH_W-1:0] LEAD_SPACE_TC = PH_W'(LEAD_SPACE - 1);
  localparam logic [PH_W-1:0] REP_SPACE_TC  = PH_W'(REP_SPACE - 1);
  localparam logic [PH_W-1:0] BIT_MARK_TC   = PH_W'(BIT_MARK - 1);
  localparam logic [PH_W-1:0] ZERO_SPACE_TC = PH_W'(ZERO_SPACE - 1);
  localparam logic [PH_W-1:0] ONE_SPACE_TC  = PH_W'(ONE_SPACE - 1);
  localparam logic [PH_W-1:0] GAP_TC        = PH_W'(GAP_LEN - 1);
  localparam logic [4:0]      LAST_IDX      = 5'(LAST_BIT);

  nec_state_e       r_state;
  nec_state_e       w_state_nxt;
  logic [PH_W-1:0]  r_cnt;
  logic [4:0]       r_bit_idx;
  logic [31:0]      r_shift;
  logic             r_rep;
  logic             r_irda;
  logic [PH_W-1:0]  w_tc;
  logic             w_last;
  logic             w_mark_cur;
  logic             w_mark_nxt;

  // Length of the phase currently running.
  always_comb begin
    w_tc = '0;
    case (r_state)
      ST_LEAD_M: w_tc = LEAD_MARK_TC;
      ST_LEAD_S: w_tc = r_rep ? REP_SPACE_TC : LEAD_SPACE_TC;
      ST_BIT_M:  w_tc = BIT_MARK_TC;
      ST_BIT_S:  w_tc = r_shift[0] ? ONE_SPACE_TC : ZERO_SPACE_TC;
      ST_STOP_M: w_tc = BIT_MARK_TC;
      ST_GAP:    w_tc = GAP_TC;
      default:   w_tc = '0;
    endcase
    w_last = (r_cnt == w_tc);
  end

  // Next-state decode and status outputs; iSEND wins over iREPEAT.
  always_comb begin
    w_state_nxt = r_state;
    oREADY      = 1'b0;
    oDONE       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        oREADY = 1'b1;
        if (iSEND || iREPEAT) w_state_nxt = ST_LEAD_M;
      end
      ST_LEAD_M: if (w_last) w_state_nxt = ST_LEAD_S;
      ST_LEAD_S: if (w_last) w_state_nxt = r_rep ? ST_STOP_M : ST_BIT_M;
      ST_BIT_M:  if (w_last) w_state_nxt = ST_BIT_S;
      ST_BIT_S: begin
        if (w_last) w_state_nxt = (r_bit_idx == LAST_IDX) ? ST_STOP_M : ST_BIT_M;
      end
      ST_STOP_M: if (w_last) w_state_nxt = ST_GAP;
      ST_GAP: begin
        oDONE = w_last;
        if (w_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge iCLK) begin
    if (!iRST_n) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Phase counter, bit shifter, repeat flag and the registered IRDA line.
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_rep     <= 1'b0;
      r_irda    <= 1'b1;
    end else begin
      r_irda <= ~is_mark(w_state_nxt);

      if ((w_state_nxt != r_state) || (r_state == ST_IDLE)) r_cnt <= '0;
      else                                                  r_cnt <= r_cnt + 1'b1;

      if (r_state == ST_IDLE) begin
        if (iSEND) begin
          r_shift   <= iDATA;
          r_rep     <= 1'b0;
          r_bit_idx <= '0;
        end else if (iREPEAT) begin
          r_rep     <= 1'b1;
        end
      end

      if ((r_state == ST_BIT_S) && w_last && (r_bit_idx != LAST_IDX)) begin
        r_bit_idx <= r_bit_idx + 1'b1;
        r_shift   <= {1'b0, r_shift[31:1]};
      end
    end
  end

  assign w_mark_cur = is_mark(r_state);
  assign w_mark_nxt = is_mark(w_state_nxt);
  assign oIRDA      = r_irda;

  ir_carrier_gen #(
    .CARR_HALF (CARR_HALF)
  ) u_carrier (
    .i_clk     (iCLK),
    .i_rst_n   (iRST_n),
    .i_en      (w_mark_nxt),
    .i_restart (w_mark_nxt & ~w_mark_cur),
    .o_carrier (oIR_LED)
  );

endmodule

// File: tb/tb_ir_nec_tx.sv
// Bench for ir_nec_tx with shortened timing. A segment-level model of the
// NEC waveform predicts every output cycle; a capture task also measures
// the line and decodes frames for literal checks.
module tb_ir_nec_tx;

  localparam int T_LM  = 40;
  localparam int T_LS  = 20;
  localparam int T_RS  = 10;
  localparam int T_BM  = 3;
  localparam int T_ZS  = 3;
  localparam int T_OS  = 9;
  localparam int T_GAP = 30;
  localparam int T_CH  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        send = 1'b0;
  logic        rpt = 1'b0;
  logic [31:0] data = '0;
  logic        ready, done, irda, led;

  ir_nec_tx #(
    .LEAD_MARK (T_LM), .LEAD_SPACE (T_LS), .REP_SPACE (T_RS),
    .BIT_MARK (T_BM), .ZERO_SPACE (T_ZS), .ONE_SPACE (T_OS),
    .GAP_LEN (T_GAP), .CARR_HALF (T_CH)
  ) dut (
    .iCLK (clk), .iRST_n (rst_n), .iSEND (send), .iREPEAT (rpt),
    .iDATA (data), .oREADY (ready), .oDONE (done), .oIRDA (irda),
    .oIR_LED (led)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;
  int done_cnt = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- model ----------------
  typedef struct packed {
    logic irda;
    logic led;
    logic rdy;
    logic dn;
  } exp_t;

  localparam exp_t IDLE_E = 4'b1010;

  exp_t q[$];
  exp_t cur = IDLE_E;

  function automatic void push_seg(input logic lvl, input int len, input bit is_gap);
    exp_t e;
    for (int k = 0; k < len; k++) begin
      e.irda = lvl;
      e.led  = (lvl == 1'b0) && (((k / T_CH) % 2) == 0);
      e.rdy  = 1'b0;
      e.dn   = is_gap && (k == len - 1);
      q.push_back(e);
    end
  endfunction

  function automatic void build(input logic [31:0] d, input bit rep);
    push_seg(1'b0, T_LM, 1'b0);
    if (rep) begin
      push_seg(1'b1, T_RS, 1'b0);
    end else begin
      push_seg(1'b1, T_LS, 1'b0);
      for (int i = 0; i < 32; i++) begin
        push_seg(1'b0, T_BM, 1'b0);
        push_seg(1'b1, d[i] ? T_OS : T_ZS, 1'b0);
      end
    end
    push_seg(1'b0, T_BM, 1'b0);
    push_seg(1'b1, T_GAP, 1'b1);
  endfunction

  // Cycles from first mark to the end of the stop mark.
  function automatic int frame_cycles(input logic [31:0] d, input bit rep);
    int n;
    n = T_LM + T_BM;
    if (rep) return n + T_RS;
    n += T_LS;
    for (int i = 0; i < 32; i++) n += T_BM + (d[i] ? T_OS : T_ZS);
    return n;
  endfunction

  // Model advance: a request is taken only if the previous cycle showed ready.
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      cur = IDLE_E;
    end else begin
      if (cur.rdy && (send || rpt)) begin
        if (send) begin
          build(data, 1'b0);
          chk("model_len", q.size(), frame_cycles(data, 1'b0) + T_GAP);
        end else begin
          build(data, 1'b1);
          chk("model_len", q.size(), frame_cycles(data, 1'b1) + T_GAP);
        end
      end
      if (q.size() > 0) cur = q.pop_front();
      else              cur = IDLE_E;
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_irda",  irda,  cur.irda);
      chk("cyc_led",   led,   cur.led);
      chk("cyc_ready", ready, cur.rdy);
      chk("cyc_done",  done,  cur.dn);
    end
    if (done === 1'b1) done_cnt++;
  end

  // ---------------- line capture / decode ----------------
  int          runs[$];
  logic [15:0] led_first;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Records alternating low/high run lengths from the first mark to oDONE.
  task automatic capture(input int budget);
    int   run;
    logic lvl;
    bit   fin;
    bit   found;
    runs.delete();
    led_first = '0;
    found = 1'b0;
    fin   = 1'b0;
    for (int n = 0; n < 64 && !found; n++) begin
      @(negedge clk);
      if (irda === 1'b0) found = 1'b1;
    end
    chk("capture_start", found, 1);
    if (found) begin
      lvl = 1'b0;
      run = 1;
      led_first[0] = led;
      for (int c = 1; c < budget && !fin; c++) begin
        @(negedge clk);
        if (c < 16) led_first[c[3:0]] = led;
        if (irda === lvl) run++;
        else begin
          runs.push_back(run);
          lvl = irda;
          run = 1;
        end
        if (done === 1'b1) begin
          runs.push_back(run);
          fin = 1'b1;
        end
      end
      chk("capture_done", fin, 1);
    end
  endtask

  task automatic check_data(input string tag, input logic [31:0] exp_d,
                            input int exp_total);
    logic [31:0] d;
    int          tot;
    chk({tag, "_runs"}, runs.size(), 68);
    if (runs.size() == 68) begin
      d = '0;
      for (int i = 0; i < 32; i++) d[i] = (runs[3 + 2 * i] > (T_ZS + T_OS) / 2);
      tot = 0;
      for (int i = 0; i < 67; i++) tot += runs[i];
      chk({tag, "_lead_mark"}, runs[0], 40);
      chk({tag, "_lead_space"}, runs[1], 20);
      chk({tag, "_data"}, d, exp_d);
      chk({tag, "_stop"}, runs[66], 3);
      chk({tag, "_gap"}, runs[67], 30);
      chk({tag, "_total"}, tot, exp_total);
      chk({tag, "_carrier"}, led_first, 16'h0F0F);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;

    repeat (3) tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;

    // Idle after reset.
    repeat (1000) tick();
    chk("idle_done_cnt", done_cnt, 0);

    // Pin the model against hand-computed durations.
    chk("pin_zero", frame_cycles(32'h0, 1'b0), 255);
    chk("pin_ef10", frame_cycles(32'hEF10_FE01, 1'b0), 351);
    chk("pin_rep",  frame_cycles(32'h0, 1'b1), 53);

    // Data frame.
    data = 32'hEF10_FE01;
    send = 1'b1;
    tick();
    send = 1'b0;
    capture(2000);
    check_data("frame", 32'hEF10_FE01, 351);
    repeat (5) tick();

    // Repeat code.
    rpt = 1'b1;
    tick();
    rpt = 1'b0;
    capture(2000);
    chk("rep_runs", runs.size(), 4);
    if (runs.size() == 4) begin
      chk("rep_lead_mark", runs[0], 40);
      chk("rep_space", runs[1], 10);
      chk("rep_stop", runs[2], 3);
      chk("rep_gap", runs[3], 30);
      chk("rep_total", runs[0] + runs[1] + runs[2], 53);
      chk("rep_carrier", led_first, 16'h0F0F);
    end
    repeat (5) tick();

    // iSEND and iREPEAT together: data frame wins.
    data = 32'h0;
    send = 1'b1;
    rpt  = 1'b1;
    tick();
    send = 1'b0;
    rpt  = 1'b0;
    capture(2000);
    check_data("both", 32'h0, 255);
    repeat (5) tick();

    // Second request during a bit space must be ignored.
    data = 32'hEF10_FE01;
    d0   = done_cnt;
    send = 1'b1;
    tick();
    send = 1'b0;
    fork
      capture(2000);
      begin
        repeat (100) tick();
        send = 1'b1;
        rpt  = 1'b1;
        data = 32'h1234_5678;
        tick();
        send = 1'b0;
        rpt  = 1'b0;
      end
    join
    check_data("busy", 32'hEF10_FE01, 351);
    repeat (20) tick();
    chk("busy_one_done", done_cnt - d0, 1);

    // Reset in the middle of bit 12.
    data = 32'hEF10_FE01;
    send = 1'b1;
    tick();
    send = 1'b0;
    repeat (156) tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_irda", irda, 1);
    chk("rst_led", led, 0);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    #1;
    rst_n = 1'b1;
    tick();
    data = 32'h5AA5_C03F;
    send = 1'b1;
    tick();
    send = 1'b0;
    capture(2000);
    check_data("after_rst", 32'h5AA5_C03F, frame_cycles(32'h5AA5_C03F, 1'b0));
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
